// File: rtl/pipeline_stall_controller.sv
// pipeline_stall_controller
// Central freeze/flush sequencer for the 5-stage pipeline. Merges the ID
// hazard, the EXE branch-taken and the MEM SRAM handshake into one
// prioritised set of per-stage controls (mem stall > branch > hazard),
// tracks multi-cycle memory waits with a timeout, and keeps saturating
// statistics counters.
//
// Ports
//   clk, rst            : rising-edge clock, async active-low reset
//   hazard_detected     : RAW hazard on the instruction in ID
//   branch_taken        : branch resolved taken in EXE
//   mem_req, mem_ready  : MEM-stage SRAM request / completion
//   clear_stats         : synchronous clear of the statistics counters
//   pc_freeze .. mem_wb_flush : per-stage controls, combinational (Mealy)
//   mem_timeout_err     : sticky fatal flag, registered
//   hazard_stall_cnt, mem_wait_cnt, flush_cnt : saturating statistics
module pipeline_stall_controller #(
    parameter int unsigned MEM_TIMEOUT = 64,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hazard_detected,
    input  logic             branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    input  logic             clear_stats,
    output logic             pc_freeze,
    output logic             if_id_freeze,
    output logic             if_id_flush,
    output logic             id_exe_freeze,
    output logic             id_exe_flush,
    output logic             exe_mem_freeze,
    output logic             mem_wb_flush,
    output logic             mem_timeout_err,
    output logic [CNT_W-1:0] hazard_stall_cnt,
    output logic [CNT_W-1:0] mem_wait_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int unsigned       WAIT_W    = $clog2(MEM_TIMEOUT) + 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_ERROR    = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [WAIT_W-1:0] wait_cnt;
    logic              mem_stall;
    logic              act_branch;
    logic              act_hazard;

    // Saturating increment shared by the statistics counters.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    // Action decode: which of the prioritised actions applies this cycle.
    always_comb begin
        mem_stall  = 1'b0;
        act_branch = 1'b0;
        act_hazard = 1'b0;
        case (state)
            ST_RUN: begin
                mem_stall  = mem_req & ~mem_ready;
                act_branch = ~mem_stall & branch_taken;
                act_hazard = ~mem_stall & ~branch_taken & hazard_detected;
            end
            // Only mem_ready ends a wait; a dropped mem_req is irrelevant.
            ST_MEM_WAIT: mem_stall = ~mem_ready;
            default: ;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_RUN;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; the wait counter already holds the cycles seen so
    // far, so the last allowed stall cycle is when it equals MEM_TIMEOUT-1.
    always_comb begin
        state_next = state;
        case (state)
            ST_RUN: begin
                if (mem_req && !mem_ready) begin
                    state_next = ST_MEM_WAIT;
                end
            end
            ST_MEM_WAIT: begin
                if (mem_ready) begin
                    state_next = ST_RUN;
                end else if (wait_cnt == WAIT_LAST) begin
                    state_next = ST_ERROR;
                end
            end
            ST_ERROR: state_next = ST_ERROR;
            default:  state_next = ST_RUN;
        endcase
    end

    // Control outputs (Mealy): freezes on stall/error, flushes on branch,
    // bubble insertion on hazard.
    always_comb begin
        pc_freeze      = 1'b0;
        if_id_freeze   = 1'b0;
        if_id_flush    = 1'b0;
        id_exe_freeze  = 1'b0;
        id_exe_flush   = 1'b0;
        exe_mem_freeze = 1'b0;
        mem_wb_flush   = 1'b0;
        if (state == ST_ERROR || mem_stall) begin
            pc_freeze      = 1'b1;
            if_id_freeze   = 1'b1;
            id_exe_freeze  = 1'b1;
            exe_mem_freeze = 1'b1;
            mem_wb_flush   = 1'b1;
        end else if (act_branch) begin
            if_id_flush  = 1'b1;
            id_exe_flush = 1'b1;
        end else if (act_hazard) begin
            pc_freeze    = 1'b1;
            if_id_freeze = 1'b1;
            id_exe_flush = 1'b1;
        end
    end

    // Consecutive mem-stall counter; the first stall cycle is seen in RUN.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt <= '0;
        end else begin
            case (state)
                ST_RUN:      wait_cnt <= mem_stall ? WAIT_W'(1) : '0;
                ST_MEM_WAIT: if (mem_stall) wait_cnt <= wait_cnt + WAIT_W'(1);
                default:     wait_cnt <= wait_cnt;
            endcase
        end
    end

    // Sticky fatal flag, cleared only by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_timeout_err <= 1'b0;
        end else if (state_next == ST_ERROR) begin
            mem_timeout_err <= 1'b1;
        end
    end

    // Statistics; clear wins over increment, ERROR cycles never count
    // because no action is decoded there.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hazard_stall_cnt <= '0;
            mem_wait_cnt     <= '0;
            flush_cnt        <= '0;
        end else if (clear_stats) begin
            hazard_stall_cnt <= '0;
            mem_wait_cnt     <= '0;
            flush_cnt        <= '0;
        end else begin
            if (act_hazard) hazard_stall_cnt <= sat_inc(hazard_stall_cnt);
            if (mem_stall)  mem_wait_cnt     <= sat_inc(mem_wait_cnt);
            if (act_branch) flush_cnt        <= sat_inc(flush_cnt);
        end
    end

endmodule
